// File: rtl/tuple_in_ctrl_if.sv
// Stream-side and engine-side signals of the tuple input controller.
// The slave modport is the controller's view; master is the surrounding environment.
interface tuple_in_ctrl_if #(
   parameter int TUPLE_W = 128,
   parameter int CNT_W   = 16
);
   logic               tctl_avalid;
   logic               tctl_aready;
   logic [TUPLE_W-1:0] tctl_atuser;
   logic               tctl_atlast;
   logic               tctl_sof;
   logic               tctl_stall;
   logic               tctl_tvalid;
   logic [TUPLE_W-1:0] tctl_tdata;
   logic               tctl_tready;
   logic [CNT_W-1:0]   tctl_pkt_cnt;
   logic [CNT_W-1:0]   tctl_drop_cnt;

   modport slave (
      input  tctl_avalid, tctl_aready, tctl_atuser, tctl_atlast, tctl_tready,
      output tctl_sof, tctl_stall, tctl_tvalid, tctl_tdata, tctl_pkt_cnt, tctl_drop_cnt
   );

   modport master (
      output tctl_avalid, tctl_aready, tctl_atuser, tctl_atlast, tctl_tready,
      input  tctl_sof, tctl_stall, tctl_tvalid, tctl_tdata, tctl_pkt_cnt, tctl_drop_cnt
   );
endinterface

// File: rtl/tuple_in_ctrl.sv
// Captures tuser on the first accepted beat of each packet and queues it in a
// small first-word-fall-through FIFO that feeds the engine tuple port.
//
// state  | meaning
// IDLE   | waiting for the first beat of a packet (next beat is SOF)
// IN_PKT | inside a packet, waiting for the tlast beat
module tuple_in_ctrl #(
   parameter int TUPLE_W = 128,
   parameter int DEPTH   = 4,
   parameter int CNT_W   = 16
) (
   input  logic tctl_aclk,
   input  logic tctl_arst,
   tuple_in_ctrl_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0]   OCC_FULL = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   OCC_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic {IDLE = 1'b0, IN_PKT = 1'b1} state_t;

   state_t             state_q, state_d;
   logic [TUPLE_W-1:0] mem_q [DEPTH];
   logic [TUPLE_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]     occ_q, occ_d;
   logic               tvalid_q, tvalid_d;
   logic               stall_q, stall_d;
   logic [TUPLE_W-1:0] tdata_q, tdata_d;
   logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
   logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

   logic beat, push_req, pop, push_ok, drop, full;

   always_comb begin
      beat     = bus.tctl_avalid & bus.tctl_aready;
      push_req = beat & (state_q == IDLE);
      pop      = tvalid_q & bus.tctl_tready;
      full     = (occ_q == OCC_FULL);
      // A pop in the same cycle frees the slot a full FIFO would otherwise lack.
      push_ok  = push_req & (~full | pop);
      drop     = push_req & full & ~pop;

      state_d = state_q;
      if (beat) state_d = bus.tctl_atlast ? IDLE : IN_PKT;

      mem_d = mem_q;
      if (push_ok) mem_d[wr_ptr_q] = bus.tctl_atuser;

      wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = pop     ? rd_ptr_q + PTR_ONE : rd_ptr_q;

      occ_d = occ_q;
      case ({push_ok, pop})
         2'b10:   occ_d = occ_q + OCC_ONE;
         2'b01:   occ_d = occ_q - OCC_ONE;
         default: occ_d = occ_q;
      endcase

      tvalid_d = (occ_d != '0);
      stall_d  = (occ_d == OCC_FULL);

      // New head is the tuple being written when the FIFO drains to it this cycle.
      tdata_d = tdata_q;
      if (occ_d != '0) begin
         if (push_ok && (wr_ptr_q == rd_ptr_d)) tdata_d = bus.tctl_atuser;
         else                                  tdata_d = mem_q[rd_ptr_d];
      end

      pkt_cnt_d  = (push_ok && pkt_cnt_q  != CNT_MAX) ? pkt_cnt_q  + CNT_ONE : pkt_cnt_q;
      drop_cnt_d = (drop    && drop_cnt_q != CNT_MAX) ? drop_cnt_q + CNT_ONE : drop_cnt_q;
   end

   always_ff @(posedge tctl_aclk) begin
      if (tctl_arst) begin
         state_q    <= IDLE;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         occ_q      <= '0;
         tvalid_q   <= 1'b0;
         stall_q    <= 1'b0;
         tdata_q    <= '0;
         pkt_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         occ_q      <= occ_d;
         tvalid_q   <= tvalid_d;
         stall_q    <= stall_d;
         tdata_q    <= tdata_d;
         pkt_cnt_q  <= pkt_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign bus.tctl_sof      = bus.tctl_avalid & (state_q == IDLE);
   assign bus.tctl_stall    = stall_q;
   assign bus.tctl_tvalid   = tvalid_q;
   assign bus.tctl_tdata    = tdata_q;
   assign bus.tctl_pkt_cnt  = pkt_cnt_q;
   assign bus.tctl_drop_cnt = drop_cnt_q;
endmodule
